// File: rtl/booth_mult_pipe_if.sv
// Handshake and data bundle for booth_mult_pipe: operation request side and product side.
// The master modport belongs to the producer/consumer pair; the slave modport to the multiplier.
interface booth_mult_pipe_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_md;
   logic [WIDTH-1:0]     in_mr;
   logic                 in_tc;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_product;
   logic [TAG_W-1:0]     out_tag;

   modport master (
      output in_valid, in_md, in_mr, in_tc, in_tag, out_ready,
      input  in_ready, out_valid, out_product, out_tag
   );

   modport slave (
      input  in_valid, in_md, in_mr, in_tc, in_tag, out_ready,
      output in_ready, out_valid, out_product, out_tag
   );
endinterface

// File: rtl/booth_mult_pipe.sv
// Three-stage radix-4 Booth multiplier, signed/unsigned per operation, valid/ready on both sides.
// S1 captures operands, S2 holds shifted partial products, S3 holds the sum and drives the output.
module booth_mult_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input logic              clk,
   input logic              rst_n,
   booth_mult_pipe_if.slave bus
);
   // Partial products and sum are kept modulo 2^(2*WIDTH); higher bits never reach the output.
   localparam int PROD_W = 2 * WIDTH;
   localparam int NG     = WIDTH / 2 + 1;

   logic                 v1, v2, v3;
   logic                 load1, load2, load3;
   logic [WIDTH-1:0]     md1, mr1;
   logic                 tc1;
   logic [TAG_W-1:0]     tag1, tag2, tag3;
   logic [PROD_W-1:0]    md_ext;
   logic [WIDTH+2:0]     mr_ext;
   logic [PROD_W-1:0]    pp_d [NG];
   logic [PROD_W-1:0]    pp_q [NG];
   logic [PROD_W-1:0]    sum;
   logic [PROD_W-1:0]    prod3;

   function automatic logic [PROD_W-1:0] booth_pp(input logic [PROD_W-1:0] m,
                                                  input logic [2:0]        grp);
      case (grp)
         3'b001, 3'b010: booth_pp = m;
         3'b011:         booth_pp = m << 1;
         3'b100:         booth_pp = ~(m << 1) + PROD_W'(1);
         3'b101, 3'b110: booth_pp = ~m + PROD_W'(1);
         default:        booth_pp = '0;
      endcase
   endfunction

   // A stage loads when it is empty or its contents move on this cycle.
   assign load3 = !v3 || bus.out_ready;
   assign load2 = !v2 || load3;
   assign load1 = !v1 || load2;

   assign bus.in_ready    = load1;
   assign bus.out_valid   = v3;
   assign bus.out_product = prod3;
   assign bus.out_tag     = tag3;

   always_comb begin
      md_ext = {{WIDTH{tc1 & md1[WIDTH-1]}}, md1};
      // Two extension bits plus the implied zero below the LSB.
      mr_ext = {{2{tc1 & mr1[WIDTH-1]}}, mr1, 1'b0};
      for (int j = 0; j < NG; j++) begin
         pp_d[j] = booth_pp(md_ext, mr_ext[2*j +: 3]) << (2 * j);
      end
   end

   always_comb begin
      sum = '0;
      for (int j = 0; j < NG; j++) begin
         sum = sum + pp_q[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         v3    <= 1'b0;
         md1   <= '0;
         mr1   <= '0;
         tc1   <= 1'b0;
         tag1  <= '0;
         tag2  <= '0;
         tag3  <= '0;
         pp_q  <= '{default: '0};
         prod3 <= '0;
      end else begin
         if (load1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
               md1  <= bus.in_md;
               mr1  <= bus.in_mr;
               tc1  <= bus.in_tc;
               tag1 <= bus.in_tag;
            end
         end
         if (load2) begin
            v2 <= v1;
            if (v1) begin
               pp_q <= pp_d;
               tag2 <= tag1;
            end
         end
         if (load3) begin
            v3 <= v2;
            if (v2) begin
               prod3 <= sum;
               tag3  <= tag2;
            end
         end
      end
   end
endmodule

// File: tb/tb_booth_mult_pipe.sv
// Self-checking bench for booth_mult_pipe: directed vectors, stream, stall and reset sequences
// on an 8-bit instance, plus randomized handshake traffic at widths 8, 12 and 16.
module tb_booth_mult_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_checks = 0;
   bit rnd_go = 1'b0;
   bit rnd_done [3];

   logic [31:0] q8_prod[$];
   logic [3:0]  q8_tag[$];

   typedef struct {
      bit          tc;
      logic [7:0]  md;
      logic [7:0]  mr;
      logic [15:0] prod;
   } vec_t;
   vec_t vecs [9];

   booth_mult_pipe_if #(.WIDTH(8), .TAG_W(4)) b8 ();
   booth_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(b8));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: operands interpreted as plain integers, product reduced to 2*w bits.
   function automatic logic [31:0] ref_mul(input int w, input bit tc,
                                           input logic [31:0] md, input logic [31:0] mr);
      longint a, b, p;
      a = longint'(md);
      b = longint'(mr);
      if (tc && md[w-1]) a = a - (longint'(1) << w);
      if (tc && mr[w-1]) b = b - (longint'(1) << w);
      p = a * b;
      p = p & ((longint'(1) << (2 * w)) - 1);
      return p[31:0];
   endfunction

   // One cycle on the 8-bit instance: drive after a falling edge, sample 1 ns later, score.
   task automatic cyc8(input bit iv, input bit tc, input logic [7:0] md, input logic [7:0] mr,
                       input logic [3:0] tag, input bit ordy, output bit took, output bit got);
      b8.in_valid = iv;  b8.in_tc = tc;  b8.in_md = md;  b8.in_mr = mr;
      b8.in_tag = tag;   b8.out_ready = ordy;
      #1;
      took = iv && b8.in_ready;
      got  = b8.out_valid && ordy;
      if (got) begin
         if (q8_prod.size() == 0) check("spurious_out_valid", 64'(b8.out_valid), 64'd0);
         else begin
            check("product", 64'(b8.out_product), 64'(q8_prod.pop_front()));
            check("tag", 64'(b8.out_tag), 64'(q8_tag.pop_front()));
         end
      end
      if (took) begin
         q8_prod.push_back(ref_mul(8, tc, 32'(md), 32'(mr)));
         q8_tag.push_back(tag);
      end
      @(negedge clk);
   endtask

   task automatic issue_measure(input string name, input bit tc, input logic [7:0] md,
                                input logic [7:0] mr, input logic [3:0] tag);
      bit took, got;
      int lat;
      cyc8(1'b1, tc, md, mr, tag, 1'b1, took, got);
      check({name, "_accept"}, 64'(took), 64'd1);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
         lat++;
         cyc8(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, took, got);
      end
      check({name, "_seen"}, 64'(got), 64'd1);
      check({name, "_latency"}, 64'(lat), 64'd3);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_rnd
      localparam int W = 8 + 4 * g;
      booth_mult_pipe_if #(.WIDTH(W), .TAG_W(4)) rbus ();
      booth_mult_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(rbus));
      logic [31:0] q_prod[$];
      logic [3:0]  q_tag[$];

      initial begin
         logic [3:0]   next_tag;
         logic [W-1:0] md, mr;
         bit           tc, iv, ordy, took, got;
         rnd_done[g] = 1'b0;
         rbus.in_valid = 1'b0;  rbus.in_md = '0;  rbus.in_mr = '0;
         rbus.in_tc = 1'b0;     rbus.in_tag = '0; rbus.out_ready = 1'b0;
         next_tag = 4'h0;
         wait (rnd_go);
         @(negedge clk);
         for (int c = 0; c < 400; c++) begin
            iv   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(3) != 0);
            if (c >= 370) begin
               iv   = 1'b0;
               ordy = 1'b1;
            end
            tc = 1'($urandom_range(1));
            md = W'($urandom);
            mr = W'($urandom);
            rbus.in_valid = iv;  rbus.in_tc = tc;  rbus.in_md = md;  rbus.in_mr = mr;
            rbus.in_tag = next_tag;  rbus.out_ready = ordy;
            #1;
            took = iv && rbus.in_ready;
            got  = rbus.out_valid && ordy;
            if (got) begin
               if (q_prod.size() == 0)
                  check($sformatf("rnd_w%0d_spurious", W), 64'(rbus.out_valid), 64'd0);
               else begin
                  check($sformatf("rnd_w%0d_product", W), 64'(rbus.out_product),
                        64'(q_prod.pop_front()));
                  check($sformatf("rnd_w%0d_tag", W), 64'(rbus.out_tag), 64'(q_tag.pop_front()));
               end
            end
            if (took) begin
               q_prod.push_back(ref_mul(W, tc, 32'(md), 32'(mr)));
               q_tag.push_back(next_tag);
               next_tag++;
            end
            @(negedge clk);
         end
         check($sformatf("rnd_w%0d_drained", W), 64'(q_prod.size()), 64'd0);
         rnd_done[g] = 1'b1;
      end
   end

   initial begin
      bit took, got;
      int took_n, ng, first, last;
      logic [3:0] tg;

      vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
      vecs[1] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
      vecs[2] = '{1'b1, 8'h80, 8'h02, 16'hFF00};
      vecs[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
      vecs[4] = '{1'b0, 8'h80, 8'h02, 16'h0100};
      vecs[5] = '{1'b0, 8'h00, 8'hA5, 16'h0000};
      vecs[6] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
      vecs[7] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
      vecs[8] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};

      b8.in_valid = 1'b0;  b8.in_md = '0;  b8.in_mr = '0;
      b8.in_tc = 1'b0;     b8.in_tag = '0; b8.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_out_valid", 64'(b8.out_valid), 64'd0);
      check("reset_out_product", 64'(b8.out_product), 64'd0);
      check("reset_out_tag", 64'(b8.out_tag), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", 64'(b8.in_ready), 64'd1);

      // Directed table: each product checked in cyc8 against the table's own constant too.
      for (int i = 0; i < 9; i++) begin
         check($sformatf("vec%0d_model", i), 64'(ref_mul(8, vecs[i].tc, 32'(vecs[i].md),
               32'(vecs[i].mr))), 64'(vecs[i].prod));
         issue_measure($sformatf("vec%0d", i), vecs[i].tc, vecs[i].md, vecs[i].mr, 4'(i));
      end

      // Back-to-back stream, alternating mode.
      took_n = 0;  ng = 0;  first = -1;  last = -1;
      for (int c = 0; c < 20; c++) begin
         tg = 4'(took_n);
         cyc8(took_n < 8, tg[0], 8'($urandom), 8'($urandom), tg, 1'b1, took, got);
         if (took) took_n++;
         if (got) begin
            ng++;
            if (first < 0) first = c;
            last = c;
         end
      end
      check("stream_accepted", 64'(took_n), 64'd8);
      check("stream_outputs", 64'(ng), 64'd8);
      check("stream_first_cycle", 64'(first), 64'd3);
      check("stream_contiguous", 64'(last - first), 64'd7);

      // Backpressure: offer 5 operations with the sink stalled; data changes while not ready.
      took_n = 0;
      for (int c = 0; c < 6; c++) begin
         cyc8(1'b1, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 4'(took_n), 1'b0,
              took, got);
         if (took) took_n++;
         if (b8.out_valid) begin
            check("stall_product", 64'(b8.out_product), 64'(q8_prod[0]));
            check("stall_tag", 64'(b8.out_tag), 64'(q8_tag[0]));
         end
      end
      check("stall_accepted", 64'(took_n), 64'd3);
      check("stall_in_ready", 64'(b8.in_ready), 64'd0);
      check("stall_out_valid", 64'(b8.out_valid), 64'd1);
      ng = 0;  first = -1;  last = -1;
      for (int c = 0; c < 15; c++) begin
         cyc8(took_n < 5, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 4'(took_n), 1'b1,
              took, got);
         if (took) took_n++;
         if (got) begin
            ng++;
            if (first < 0) first = c;
            last = c;
         end
      end
      check("release_outputs", 64'(ng), 64'd5);
      check("release_contiguous", 64'(last - first), 64'd4);
      check("release_queue_empty", 64'(q8_prod.size()), 64'd0);

      // Asynchronous reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         cyc8(1'b1, 1'(i), 8'($urandom), 8'($urandom), 4'(10 + i), 1'b1, took, got);
      end
      check("pre_reset_out_valid", 64'(b8.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      b8.in_valid = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(b8.out_valid), 64'd0);
      check("async_rst_out_product", 64'(b8.out_product), 64'd0);
      check("async_rst_out_tag", 64'(b8.out_tag), 64'd0);
      q8_prod.delete();
      q8_tag.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue_measure("post_reset", 1'b1, 8'h80, 8'h7F, 4'hC);
      ng = 0;
      for (int c = 0; c < 5; c++) begin
         cyc8(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, took, got);
         if (got) ng++;
      end
      check("post_reset_no_stale", 64'(ng), 64'd0);

      // Randomized traffic on the 8/12/16-bit instances.
      rnd_go = 1'b1;
      begin
         int c;
         c = 0;
         while (!(rnd_done[0] && rnd_done[1] && rnd_done[2]) && c < 3000) begin
            @(negedge clk);
            c++;
         end
      end
      for (int g = 0; g < 3; g++) check($sformatf("rnd%0d_done", g), 64'(rnd_done[g]), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
